skew_delay_buffer: RTL and testbench

- Parametrised multi-channel delay line with enable, valid tracking and flush.
- Channel i is delayed by a per-channel number of register stages, so it either skews a parallel vector into the diagonal wavefront a systolic PE array needs, or de-skews the array outputs back into aligned vectors.
- Sits between the line/weight buffers and the systolic array, and between the array and the output writer.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/skew_delay_buffer_lane.sv | 65 ++++++
 rtl/skew_delay_buffer.sv | 59 +++++
 tb/tb_skew_delay_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN datapath blocks.
//   skew_depth(ch, num_ch, deskew) : register-stage count of channel ch in a
//                                    skew/deskew delay line (1 .. num_ch).
//   ch_lsb(ch, data_width)         : LSB of channel ch on a flat channel bus.
// Flat bus convention: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam bit MODE_SKEW   = 1'b0;
   localparam bit MODE_DESKEW = 1'b1;

   // Skew mode delays channel i by 1+i (diagonal wavefront into the array);
   // deskew mode delays it by num_ch-i so the wavefront realigns.
   function automatic int skew_depth(input int ch, input int num_ch, input bit deskew);
      return (deskew == MODE_DESKEW) ? (num_ch - ch) : (1 + ch);
   endfunction

   function automatic int ch_lsb(input int ch, input int data_width);
      return ch * data_width;
   endfunction

endpackage

// File: rtl/skew_delay_buffer_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
// One channel of the skew delay buffer: a DEPTH-stage shift chain, each stage
// holding DATA_WIDTH data plus a valid bit.
//   clk, reset    : clock, synchronous active-high reset
//   en            : advance enable (0 = every stage holds)
//   flush         : synchronous clear of all stages, input discarded
//   in_valid/data : stage-0 input
//   out_valid/data: last stage (registered)
//   any_valid     : OR of all valid bits in this lane
// -----------------------------------------------------------------------------
module skew_lane #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 1,
   parameter bit ZERO_INVALID = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  any_valid
);

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH-1:0]      valid_d;

   always_comb begin
      // NOTE: every output of this block is given a hold value first, so no
      // path leaves it unassigned and no latch is inferred.
      data_d  = data_q;
      valid_d = valid_q;
      // NOTE: data stages are cleared along with the valid bits, not just the
      // valids, because the outputs must read 0 after reset or flush.
      if (reset || flush) begin
         for (int s = 0; s < DEPTH; s++) data_d[s] = '0;
         valid_d = '0;
      end else if (en) begin
         data_d[0]  = (ZERO_INVALID && !in_valid) ? '0 : in_data;
         valid_d[0] = in_valid;
         for (int s = 1; s < DEPTH; s++) begin
            data_d[s]  = data_q[s-1];
            valid_d[s] = valid_q[s-1];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples
   // its predecessor's pre-edge value, giving a true shift rather than a
   // ripple-through.
   always_ff @(posedge clk) begin
      data_q  <= data_d;
      valid_q <= valid_d;
   end

   assign out_data  = data_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];
   assign any_valid = |valid_q;

endmodule

// File: rtl/skew_delay_buffer.sv
// -----------------------------------------------------------------------------
// skew_delay_buffer
// Multi-channel delay line that skews a parallel vector into a diagonal
// wavefront (DESKEW=0, channel i delay 1+i) or realigns one (DESKEW=1,
// channel i delay NUM_CH-i).
//   clk, reset : clock, synchronous active-high reset
//   en         : advance enable; flush: clear all in-flight data
//   in_valid   : vector valid common to all channels
//   in_data    : NUM_CH*DATA_WIDTH flat bus, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data   : delayed data, same packing; out_valid: per-channel valid
//   all_valid  : all channels valid (aligned vector present)
//   pending    : any stage of any channel holds a valid bit
// -----------------------------------------------------------------------------
module skew_delay_buffer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CH       = 4,
   parameter int DESKEW       = 0,
   parameter int ZERO_INVALID = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            out_valid,
   output logic                         all_valid,
   output logic                         pending
);

   logic [NUM_CH-1:0] lane_any;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      localparam int LSB = ch_lsb(i, DATA_WIDTH);

      skew_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .DEPTH       (skew_depth(i, NUM_CH, DESKEW != 0)),
         .ZERO_INVALID(ZERO_INVALID != 0)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .flush    (flush),
         .in_valid (in_valid),
         .in_data  (in_data[LSB +: DATA_WIDTH]),
         .out_data (out_data[LSB +: DATA_WIDTH]),
         .out_valid(out_valid[i]),
         .any_valid(lane_any[i])
      );
   end

   assign all_valid = &out_valid;
   assign pending   = |lane_any;

endmodule

// File: tb/tb_skew_delay_buffer.sv
// -----------------------------------------------------------------------------
// tb_skew_delay_buffer
// Three instances share one stimulus stream: skew with zero gating, skew
// without zero gating, and deskew with zero gating. A reference model keeps
// each channel as a queue of its last D(i) accepted entries; expected outputs
// are queued at each edge and a monitor compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_skew_delay_buffer;

   localparam int DW = 8;
   localparam int NC = 4;
   localparam int NDUT = 3;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } ent_t;

   typedef struct packed {
      logic [NDUT-1:0][31:0] d;
      logic [NDUT-1:0][3:0]  v;
      logic [NDUT-1:0]       a;
      logic [NDUT-1:0]       p;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, en, flush, in_valid;
   logic [31:0] in_data;

   logic [31:0] o_data  [NDUT];
   logic [3:0]  o_valid [NDUT];
   logic        o_all   [NDUT];
   logic        o_pend  [NDUT];

   int n_cmp = 0;
   int n_err = 0;

   // configuration of each instance: {deskew, zero_invalid}
   int cfg_deskew [NDUT] = '{0, 0, 1};
   int cfg_zi     [NDUT] = '{1, 0, 1};

   ent_t line [NDUT][NC][$];
   exp_t exp_q [$];

   always #5 clk = ~clk;

   skew_delay_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DESKEW(0), .ZERO_INVALID(1)) u_skew (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .out_data(o_data[0]), .out_valid(o_valid[0]), .all_valid(o_all[0]), .pending(o_pend[0]));

   skew_delay_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DESKEW(0), .ZERO_INVALID(0)) u_skew_nz (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .out_data(o_data[1]), .out_valid(o_valid[1]), .all_valid(o_all[1]), .pending(o_pend[1]));

   skew_delay_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DESKEW(1), .ZERO_INVALID(1)) u_deskew (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .out_data(o_data[2]), .out_valid(o_valid[2]), .all_valid(o_all[2]), .pending(o_pend[2]));

   // ---------------- reference model ----------------
   function automatic int depth_of(input int c, input int ch);
      if (cfg_deskew[c] != 0) return NC - ch;
      return ch + 1;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < NDUT; c++)
         for (int i = 0; i < NC; i++) begin
            line[c][i].delete();
            for (int k = 0; k < depth_of(c, i); k++) line[c][i].push_back('0);
         end
   endtask

   // Advance the model by one clock edge and return what each DUT should show.
   task automatic model_step(input logic r, input logic e, input logic f,
                             input logic v, input logic [31:0] d, output exp_t x);
      ent_t nw;
      if (r || f) model_clear();
      else if (e) begin
         for (int c = 0; c < NDUT; c++)
            for (int i = 0; i < NC; i++) begin
               nw.v = v;
               nw.d = (cfg_zi[c] != 0 && !v) ? 8'h00 : d[i*8 +: 8];
               line[c][i].push_back(nw);
               void'(line[c][i].pop_front());
            end
      end
      for (int c = 0; c < NDUT; c++) begin
         x.p[c] = 1'b0;
         for (int i = 0; i < NC; i++) begin
            x.d[c][i*8 +: 8] = line[c][i][0].d;
            x.v[c][i]        = line[c][i][0].v;
            foreach (line[c][i][k]) if (line[c][i][k].v) x.p[c] = 1'b1;
         end
         x.a[c] = &x.v[c];
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         for (int c = 0; c < NDUT; c++) begin
            check($sformatf("dut%0d out_data", c),  o_data[c],          x.d[c]);
            check($sformatf("dut%0d out_valid", c), {28'd0, o_valid[c]}, {28'd0, x.v[c]});
            check($sformatf("dut%0d all_valid", c), {31'd0, o_all[c]},   {31'd0, x.a[c]});
            check($sformatf("dut%0d pending", c),   {31'd0, o_pend[c]},  {31'd0, x.p[c]});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic e, input logic f,
                       input logic v, input logic [31:0] d);
      exp_t x;
      reset = r; en = e; flush = f; in_valid = v; in_data = d;
      @(posedge clk);
      model_step(r, e, f, v, d, x);
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] vec;
      reset = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      model_clear();
      @(negedge clk);

      // reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);

      // single vector through the skew
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h04030201);
      idle(6);

      // stall of two cycles mid-stream
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333);
      idle(6);

      // flush mid-stream, flushed input discarded
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h01020304);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h05060708);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAAAAAA);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0C0D0E0F);
      idle(6);

      // zero gating of invalid data
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
      idle(5);

      // diagonal wavefront: channel i carries 0x10+k at cycle k+i
      for (int t = 0; t < 7; t++) begin
         vec = '0;
         for (int i = 0; i < NC; i++)
            if (t - i >= 0 && t - i <= 3) vec[i*8 +: 8] = 8'(8'h10 + t - i);
         step(1'b0, 1'b1, 1'b0, 1'b1, vec);
      end
      idle(6);

      // reset mid-stream while stalled, then restart
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h41424344);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h51525354);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h61626364);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h71727374);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h81828384);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h91929394);
      idle(6);

      // randomized traffic
      for (int k = 0; k < 400; k++)
         step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(99) < 3,
              1'($urandom_range(1)), $urandom);
      idle(6);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
